scan_uart_frame_tx: RTL
=======================

Name: scan_uart_frame_tx

Overview:
- Parametrised successor to the fixed 13-digit barcode UART sender.
- Takes a DIGITS-wide vector of 4-bit decoded barcode digits from the scan stage and serialises it as an ASCII text frame over 8N1 UART.
- Frame layout: header byte, digits, optional XOR checksum, CR, LF.
- Adds send-on-change filtering, a one-deep pending slot and a saturating drop counter.
- Sits between the barcode scanner and the board uart_tx pin, in the 50 MHz system clock domain.

Parameters:
- CLK_FRE, 50, system clock in MHz.
- UART_RATE, 115200, baud rate. BAUD_DIV = CLK_FRE*1000000/UART_RATE, truncated (434 at defaults).
- DIGITS, 13, number of 4-bit digits per frame (1..32).
- SEND_MODE, 0. 0 = send only when data differs from the last sent frame; 1 = send on every accepted scan_valid.
- CHECKSUM_EN, 1. 1 = append XOR checksum as two uppercase hex ASCII chars.
- HEADER, 8'h24, first byte of every frame ('$').

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, synchronous active-low reset.
- scan_valid, input, 1, one-cycle strobe: scan_data is valid.
- scan_data, input, DIGITS*4, digit i occupies bits [4i+3:4i]. Digit DIGITS-1 is sent first.
- uart_tx, output, 1, serial line; idles high.
- busy, output, 1, a frame is in transmission.
- frame_done, output, 1, one-cycle pulse at the end of the last stop bit of a frame.
- drop_cnt, output, 8, count of overwritten pending frames; saturating.

Behaviour:
- Reset is synchronous, active-low, and takes effect at the next clk edge, including mid-frame.
- Reset values: uart_tx=1, busy=0, frame_done=0, drop_cnt=0. FSM goes to IDLE, pending slot is emptied, last-sent record is invalidated.
- Digit to ASCII mapping: 0-9 map to 0x30-0x39; 10-15 map to 'A'-'F' (0x41-0x46).
- Checksum = XOR of the DIGITS ASCII digit bytes, sent high nibble first as hex ASCII.
- Frame length L = 1 + DIGITS + 2*CHECKSUM_EN + 2 bytes.
- UART format: start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts BAUD_DIV cycles. No gap between bytes.
- Send decision:
  - Data equal to the last-sent record with SEND_MODE=0 and the record valid: discard silently; no frame, drop_cnt unchanged.
  - The first valid after reset is always sent.
- FSM states: IDLE, LOAD, START, DATA, STOP, NEXT.
  - IDLE + scan_valid (accepted) at cycle t: data is captured into the frame register; busy=1 from t+1; LOAD at t+1 selects byte 0; uart_tx goes low (START) at t+2.
  - START, then DATA (8 bits), then STOP, each bit BAUD_DIV cycles.
  - NEXT: advance the byte index and go to START in the same cycle boundary, so there is no idle bit between bytes.
  - After the LF stop bit: frame_done=1 for one cycle, the last-sent record is updated, and busy drops the following cycle.
- Frame duration: L*10*BAUD_DIV cycles from the start-bit edge.
- scan_valid while busy: data goes to the pending slot. If the slot is already full it is overwritten and drop_cnt increments (saturates at 255).
- The send-on-change filter is applied when the pending slot is consumed, not at capture.
- Pending slot consumption: on return to IDLE a full slot launches a new frame exactly as if scan_valid had arrived in that cycle.
- scan_valid in the same cycle the slot is consumed: the new data wins; the slot content is dropped and counted.
- scan_data is sampled only in the scan_valid cycle; changes between strobes are ignored.

Decomposition:
- Package scan_uart_pkg holds:
  - the state enum;
  - constants ASCII_CR=8'h0D and ASCII_LF=8'h0A;
  - function hex2ascii(4-bit) returning 8-bit;
  - the BAUD_DIV computation helper.
- Sub-module uart_byte_tx: baud counter plus 10-bit shift register, with tx_start, tx_data[7:0], tx_ready and tx.
- The top of the block holds the frame FSM, byte mux, checksum, pending slot and filter.

Test Plan:
- Defaults, scan_data digits 6,9,0,1,2,3,4,5,6,7,8,9,2 (first = MSD), scan_valid at t:
  - busy rises at t+1; uart_tx falls at t+2;
  - bytes are "$6901234567892", then "3C", then 0x0D, 0x0A (18 bytes);
  - 78120 cycles from the start bit to the end of the frame;
  - frame_done pulses once.
- Resend identical data after frame_done:
  - SEND_MODE=0: uart_tx stays high and drop_cnt stays 0.
  - SEND_MODE=1: the identical 18-byte frame is resent.
- Three scan_valid strobes (A, B, C) during one busy frame: after frame A only C is sent, and drop_cnt=1.
- A digit value of 12 in any position transmits 0x43 ('C') in that position. With CHECKSUM_EN=0 the frame is 16 bytes.
- rst_n low for one cycle in the middle of a data bit:
  - next cycle uart_tx=1, busy=0, drop_cnt=0;
  - re-sending the previous data with SEND_MODE=0 produces a full frame.
- 300 overflow events → drop_cnt reads 255 and does not wrap.

Source files
------------

// File: rtl/scan_uart_pkg.sv
// scan_uart_pkg
// Shared definitions for the barcode frame transmitter:
//   state_t        - frame FSM states
//   ASCII_CR/LF    - frame trailer bytes
//   hex2ascii()    - 4-bit value to uppercase hex ASCII character
//   calc_baud_div()- clock cycles per UART bit (truncated)
`timescale 1ns/1ps
package scan_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
        STOP,
        NEXT
    } state_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    function automatic logic [7:0] hex2ascii(input logic [3:0] nib);
        logic [7:0] ch;
        // 'A' (0x41) minus 10 is 0x37
        if (nib < 4'd10) ch = 8'h30 + {4'h0, nib};
        else             ch = 8'h37 + {4'h0, nib};
        return ch;
    endfunction

    function automatic int calc_baud_div(input int clk_fre, input int uart_rate);
        return (clk_fre * 1000000) / uart_rate;
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// uart_byte_tx
// One 8N1 character serialiser: baud counter plus 10-bit shift register.
// Ports:
//   clk, rst_n      - clock, synchronous active-low reset
//   tx_start        - load tx_data and start a character (also accepted in
//                     the final cycle of a stop bit, giving back-to-back bytes)
//   tx_data[7:0]    - character to send
//   tx_ready        - no character in flight
//   tx              - serial line, idles high
//   bit_idx[3:0]    - current bit: 0 start, 1..8 data, 9 stop
//   bit_last        - last cycle of the current bit
//   bit_prelast     - second-to-last cycle of the current bit
// BAUD_DIV must be at least 2.
`timescale 1ns/1ps
module uart_byte_tx #(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx,
    output logic [3:0] bit_idx,
    output logic       bit_last,
    output logic       bit_prelast
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] DIV_PRE  = CW'(BAUD_DIV - 2);

    logic [CW-1:0] baud_cnt_reg;
    logic [9:0]    shift_reg;
    logic [3:0]    bit_idx_reg;
    logic          active_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            baud_cnt_reg <= '0;
            shift_reg    <= '1;
            bit_idx_reg  <= '0;
            active_reg   <= 1'b0;
        end else if (tx_start) begin
            // stop bit, data LSB first, start bit
            shift_reg    <= {1'b1, tx_data, 1'b0};
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            active_reg   <= 1'b1;
        end else if (active_reg) begin
            if (baud_cnt_reg == DIV_LAST) begin
                baud_cnt_reg <= '0;
                shift_reg    <= {1'b1, shift_reg[9:1]};
                if (bit_idx_reg == 4'd9) active_reg  <= 1'b0;
                else                     bit_idx_reg <= bit_idx_reg + 4'd1;
            end else begin
                baud_cnt_reg <= baud_cnt_reg + 1'b1;
            end
        end
    end

    assign tx          = shift_reg[0] | ~active_reg;
    assign tx_ready    = ~active_reg;
    assign bit_idx     = bit_idx_reg;
    assign bit_last    = active_reg && (baud_cnt_reg == DIV_LAST);
    assign bit_prelast = active_reg && (baud_cnt_reg == DIV_PRE);

endmodule

// File: rtl/scan_uart_frame_tx.sv
// scan_uart_frame_tx
// Serialises a vector of decoded barcode digits as an ASCII text frame
// over 8N1 UART: HEADER, digits (MSD first), optional XOR checksum as two
// hex characters, CR, LF. Adds send-on-change filtering, a one-deep
// pending slot for scans arriving mid-frame and a saturating drop counter.
// Ports:
//   clk, rst_n          - system clock, synchronous active-low reset
//   scan_valid          - one-cycle strobe qualifying scan_data
//   scan_data           - DIGITS x 4-bit digits, digit i at [4i+3:4i]
//   uart_tx             - serial output, idles high
//   busy                - frame in transmission (incl. frame_done cycle)
//   frame_done          - one-cycle pulse after the final stop bit
//   drop_cnt[7:0]       - overwritten pending frames, saturating at 255
`timescale 1ns/1ps
module scan_uart_frame_tx
    import scan_uart_pkg::*;
#(
    parameter int         CLK_FRE     = 50,
    parameter int         UART_RATE   = 115200,
    parameter int         DIGITS      = 13,
    parameter int         SEND_MODE   = 0,
    parameter int         CHECKSUM_EN = 1,
    parameter logic [7:0] HEADER      = 8'h24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scan_valid,
    input  logic [DIGITS*4-1:0]   scan_data,
    output logic                  uart_tx,
    output logic                  busy,
    output logic                  frame_done,
    output logic [7:0]            drop_cnt
);

    localparam int BAUD_DIV  = calc_baud_div(CLK_FRE, UART_RATE);
    localparam int DW        = DIGITS * 4;
    localparam int FRAME_LEN = 1 + DIGITS + 2 * CHECKSUM_EN + 2;
    localparam logic [5:0] LAST_IDX = 6'(FRAME_LEN - 1);
    localparam logic [5:0] CR_IDX   = 6'(FRAME_LEN - 2);
    localparam logic [5:0] CSH_IDX  = 6'(DIGITS + 1);
    localparam logic [5:0] CSL_IDX  = 6'(DIGITS + 2);

    state_t         state_reg, state_next;
    logic [5:0]     byte_idx_reg, byte_idx_next;
    logic [DW-1:0]  frame_reg, frame_next;
    logic           pend_valid_reg, pend_valid_next;
    logic [DW-1:0]  pend_data_reg, pend_data_next;
    logic           last_valid_reg, last_valid_next;
    logic [DW-1:0]  last_data_reg, last_data_next;
    logic [7:0]     drop_cnt_reg, drop_cnt_next;
    logic           frame_done_reg, frame_done_next;

    logic           tx_start;
    logic           tx_ready;
    logic [3:0]     bit_idx;
    logic           bit_last;
    logic           bit_prelast;
    logic [7:0]     tx_byte;
    logic [5:0]     sel_idx;
    logic [7:0]     checksum;
    logic [DW-1:0]  cand_data;
    logic           cand_valid;
    logic           send_ok;

    // ASCII form of every captured digit
    logic [7:0] digit_ascii [DIGITS];
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_ascii
            assign digit_ascii[gi] = hex2ascii(frame_reg[4*gi +: 4]);
        end
    endgenerate

    always_comb begin
        checksum = '0;
        for (int i = 0; i < DIGITS; i++) begin
            checksum = checksum ^ digit_ascii[i];
        end
    end

    // In NEXT the byte index advances at the coming edge, so the mux must
    // already present the following byte to the serialiser.
    always_comb begin
        sel_idx = (state_reg == NEXT) ? (byte_idx_reg + 6'd1) : byte_idx_reg;
        tx_byte = ASCII_LF;
        if (sel_idx == CR_IDX) tx_byte = ASCII_CR;
        if (CHECKSUM_EN != 0) begin
            if (sel_idx == CSH_IDX) tx_byte = hex2ascii(checksum[7:4]);
            if (sel_idx == CSL_IDX) tx_byte = hex2ascii(checksum[3:0]);
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (sel_idx == 6'(DIGITS - i)) tx_byte = digit_ascii[i];
        end
        if (sel_idx == 6'd0) tx_byte = HEADER;
    end

    always_comb begin
        state_next      = state_reg;
        byte_idx_next   = byte_idx_reg;
        frame_next      = frame_reg;
        pend_valid_next = pend_valid_reg;
        pend_data_next  = pend_data_reg;
        last_valid_next = last_valid_reg;
        last_data_next  = last_data_reg;
        drop_cnt_next   = drop_cnt_reg;
        frame_done_next = 1'b0;
        tx_start        = 1'b0;

        // A fresh strobe always beats the pending slot
        cand_data  = scan_valid ? scan_data : pend_data_reg;
        cand_valid = scan_valid || pend_valid_reg;
        send_ok    = (SEND_MODE != 0) || !last_valid_reg || (cand_data != last_data_reg);

        // A strobe landing on a full slot loses the slot content, whether the
        // slot is being overwritten mid-frame or being consumed in IDLE.
        if (scan_valid && pend_valid_reg && (drop_cnt_reg != 8'hFF)) begin
            drop_cnt_next = drop_cnt_reg + 8'd1;
        end

        case (state_reg)
            IDLE: begin
                pend_valid_next = 1'b0;
                if (cand_valid && send_ok) begin
                    frame_next    = cand_data;
                    byte_idx_next = 6'd0;
                    state_next    = LOAD;
                end
            end
            LOAD: begin
                if (tx_ready) begin
                    tx_start   = 1'b1;
                    state_next = START;
                end
            end
            START: if (bit_last) state_next = DATA;
            DATA:  if (bit_last && (bit_idx == 4'd8)) state_next = STOP;
            // NEXT occupies the final cycle of the stop bit so the following
            // start bit begins with no idle gap.
            STOP:  if (bit_prelast) state_next = NEXT;
            NEXT: begin
                if (byte_idx_reg == LAST_IDX) begin
                    state_next      = IDLE;
                    frame_done_next = 1'b1;
                    last_valid_next = 1'b1;
                    last_data_next  = frame_reg;
                end else begin
                    tx_start      = 1'b1;
                    byte_idx_next = byte_idx_reg + 6'd1;
                    state_next    = START;
                end
            end
            default: state_next = IDLE;
        endcase

        if ((state_reg != IDLE) && scan_valid) begin
            pend_valid_next = 1'b1;
            pend_data_next  = scan_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            byte_idx_reg   <= '0;
            frame_reg      <= '0;
            pend_valid_reg <= 1'b0;
            pend_data_reg  <= '0;
            last_valid_reg <= 1'b0;
            last_data_reg  <= '0;
            drop_cnt_reg   <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            byte_idx_reg   <= byte_idx_next;
            frame_reg      <= frame_next;
            pend_valid_reg <= pend_valid_next;
            pend_data_reg  <= pend_data_next;
            last_valid_reg <= last_valid_next;
            last_data_reg  <= last_data_next;
            drop_cnt_reg   <= drop_cnt_next;
            frame_done_reg <= frame_done_next;
        end
    end

    uart_byte_tx #(
        .BAUD_DIV(BAUD_DIV)
    ) u_byte_tx (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_start   (tx_start),
        .tx_data    (tx_byte),
        .tx_ready   (tx_ready),
        .tx         (uart_tx),
        .bit_idx    (bit_idx),
        .bit_last   (bit_last),
        .bit_prelast(bit_prelast)
    );

    assign busy       = (state_reg != IDLE) || frame_done_reg;
    assign frame_done = frame_done_reg;
    assign drop_cnt   = drop_cnt_reg;

endmodule
